// File: rtl/seq_pulse_gen_if.sv
// Bundle between test/control logic, seq_pulse_gen and the sequence detector.
// master: control/detector side; slave: the pulse generator itself.
interface seq_pulse_gen_if #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
);
    logic             start;
    logic [CNT_W-1:0] frame_count;
    logic [GAP_W-1:0] gap;
    logic             a_in;
    logic             b_in;
    logic             sig_1;
    logic             sig_2;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] ok_count;
    logic [CNT_W-1:0] err_count;
    logic             err;

    modport master (
        output start, frame_count, gap, a_in, b_in,
        input  sig_1, sig_2, busy, done, ok_count, err_count, err
    );

    modport slave (
        input  start, frame_count, gap, a_in, b_in,
        output sig_1, sig_2, busy, done, ok_count, err_count, err
    );
endinterface

// File: rtl/seq_pulse_gen.sv
// Transmit side of the sig_1/sig_2 sequence-detector handshake; sends frames and scores a/b responses.
// Define SEQ_PULSE_GEN_STOP_ON_ERR_EN to end a run after the first failing frame's gap.
module seq_pulse_gen #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input logic            clk,
    input logic            rst,
    seq_pulse_gen_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SEND1, SEND2, GAP, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] frames_left;
    logic [CNT_W-1:0] ok_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [GAP_W-1:0] gap_len;
    logic [GAP_W-1:0] gap_left;
    logic             err_r;
    logic             bad1;
    logic             gap_last;
    logic             run_end;
    logic             frame_bad;

    assign gap_last  = (gap_left == GAP_W'(1));
    assign frame_bad = bad1 || !(bus.b_in && !bus.a_in);

`ifdef SEQ_PULSE_GEN_STOP_ON_ERR_EN
    // err_r is already updated by the first GAP cycle, so a failing frame ends the run here
    assign run_end = (frames_left == CNT_W'(1)) || err_r;
`else
    assign run_end = (frames_left == CNT_W'(1));
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = (bus.frame_count != '0) ? SEND1 : DONE;
            SEND1:   state_nxt = SEND2;
            SEND2:   state_nxt = GAP;
            GAP:     if (gap_last) state_nxt = run_end ? DONE : SEND1;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            frames_left <= '0;
            ok_cnt      <= '0;
            err_cnt     <= '0;
            gap_len     <= '0;
            gap_left    <= '0;
            err_r       <= 1'b0;
            bad1        <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        ok_cnt      <= '0;
                        err_cnt     <= '0;
                        err_r       <= 1'b0;
                        frames_left <= bus.frame_count;
                        gap_len     <= (bus.gap == '0) ? GAP_W'(1) : bus.gap;
                    end
                end
                SEND1: bad1 <= !(bus.a_in && !bus.b_in);
                SEND2: begin
                    gap_left <= gap_len;
                    if (frame_bad) begin
                        err_r <= 1'b1;
                        if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
                    end else if (ok_cnt != '1) begin
                        ok_cnt <= ok_cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    gap_left <= gap_left - GAP_W'(1);
                    if (gap_last) frames_left <= frames_left - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.sig_1     = (state == SEND1);
    assign bus.sig_2     = (state == SEND2);
    assign bus.busy      = (state == SEND1) || (state == SEND2) || (state == GAP);
    assign bus.done      = (state == DONE);
    assign bus.ok_count  = ok_cnt;
    assign bus.err_count = err_cnt;
    assign bus.err       = err_r;
endmodule

// File: doc/seq_pulse_gen.md
# seq_pulse_gen

Transmit side of the two-input one-hot sequence-detector handshake. On a start request it drives a programmed number of frames onto `sig_1`/`sig_2`. Each frame is `sig_1` for one cycle, then `sig_2` for one cycle, then an idle gap. It checks the detector's `a`/`b` responses on every frame and counts good and bad frames. It sits between test/control logic and the detector, so the detector can be exercised and monitored in-system.

## Interface
Parameters:
- `CNT_W`, default 8: width of frame count and of the ok/err counters.
- `GAP_W`, default 4: width of the inter-frame gap field.

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a run; sampled only in IDLE.
- `frame_count`  in  CNT_W  frames per run; latched on start accept.
- `gap`  in  GAP_W  idle cycles between frames; latched on start accept; 0 is treated as 1.
- `a_in`  in  1  detector `a` output.
- `b_in`  in  1  detector `b` output.
- `sig_1`  out  1  drives detector `input_sig_1`.
- `sig_2`  out  1  drives detector `input_sig_2`.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at end of run.
- `ok_count`  out  CNT_W  frames whose responses all matched.
- `err_count`  out  CNT_W  frames with any mismatch.
- `err`  out  1  sticky; set on first mismatch; cleared by start accept or `rst`.

## Operation
- FSM states: IDLE, SEND1, SEND2, GAP, DONE.
- All outputs are Moore decodes of registered state and registered counters:
  - `sig_1` = SEND1.
  - `sig_2` = SEND2.
  - `busy` = SEND1, SEND2 or GAP.
  - `done` = DONE.
- IDLE:
  - `start`=1 with latched `frame_count`≠0: clear ok/err counters and `err`, load frame and gap counters, go to SEND1.
  - `start`=1 with `frame_count`=0: clear counters, go to DONE.
- SEND1: sample the expected response `a_in`=1, `b_in`=0. Go to SEND2.
- SEND2: sample the expected response `b_in`=1, `a_in`=0. Go to GAP.
- GAP:
  - Hold for gap_eff = max(`gap`,1) cycles. The minimum of 1 covers the detector's S2 recovery cycle.
  - Then decrement the remaining-frames count.
  - Go to SEND1 if frames remain, else go to DONE.
- Frame verdict:
  - Registered at the SEND2→GAP edge: frame ok iff all four samples matched.
  - Increment `ok_count` or `err_count` accordingly.
  - On error, set `err`.
- DONE: one cycle, then IDLE. Counters and `err` hold their values until the next start accept.
- `start` outside IDLE is ignored.
- Counters saturate at all-ones; they do not wrap.
- `rst` at any cycle, including mid-frame, takes effect at the next edge:
  - State returns to IDLE.
  - All outputs and counters go to 0.
  - An in-flight frame is not counted.

## Timing
- Reset value of every output: 0.
- `start` accepted at edge N:
  - `sig_1`=1 and `busy`=1 in cycle N+1.
  - `sig_2`=1 in cycle N+2.
- Frame period is 2 + gap_eff cycles; `sig_1` and `sig_2` are never high together.
- Counter update becomes visible in the first GAP cycle of the frame.
- Run latency from the start edge to the `done` cycle is `frame_count`×(2+gap_eff)+1 cycles.
- With `frame_count`=0, `done` is high in cycle N+1.
- `a_in`/`b_in` are sampled in the same cycle as the corresponding `sig_*`. This matches the detector's combinational `a` and its registered `b`.

## Configuration
- Macro: `SEQ_PULSE_GEN_STOP_ON_ERR_EN`.
- Defined: a frame with a mismatch ends the run. The state goes GAP (full gap_eff) → DONE regardless of frames remaining; `err_count` is at most 1.
- Undefined: all `frame_count` frames are always sent; errors are only counted.

## Test plan
- Reset check: `rst` for 2 cycles → all outputs 0. `start`=1 during `rst` → no run.
- Nominal run: `frame_count`=3, `gap`=2, correct detector attached → `sig_1` pulses at N+1, N+5, N+9; `done` at N+13; `ok_count`=3, `err_count`=0, `err`=0.
- Gap zero: `frame_count`=2, `gap`=0 → frame period 3 cycles; detector stays in step; `ok_count`=2.
- Error injection: force `b_in`=0 on frame 2 of 4 → `err_count`=1, `ok_count`=3, `err`=1. With the macro defined instead → run ends after frame 2 with `ok_count`=1, `err_count`=1.
- Boundary: `frame_count`=0 → `done` at N+1, no `sig_*`. `start` pulsed mid-run → ignored. `frame_count`=255 with CNT_W=8 → `ok_count`=255, no wrap.
- Reset mid-operation: assert `rst` in SEND2 of frame 1 → all outputs 0 next cycle; no count change; a new `start` runs normally.
